map_req_arbiter: RTL and testbench

Round-robin arbiter that shares one pair of map BRAMs (untextured/textured, `xilinx_single_port_ram_read_first`, HIGH_PERFORMANCE) among `NUM_REQ` `dda_fsm` instances. It replaces the per-request IDLE/GRANT/HOLD/ASSIGN sequencing with a pipelined scheme that issues one read per cycle and routes returned data back by tag. It sits inside `dda` between the FSM map-request ports and the BRAM instances, which stay external.

---
 rtl/map_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_map_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_req_arbiter.sv
// map_req_arbiter: round-robin sharing of one pair of map BRAMs among several
// DDA FSMs. One read can be issued per cycle. Each read carries a tag through
// a shift pipeline that matches the BRAM latency, and the tag steers the
// returned cell back to the FSM that asked for it.
module map_req_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int N            = 24,
  parameter int ADDR_W       = $clog2(N*N),
  parameter int DATA_W       = 4,
  parameter int BRAM_LATENCY = 2,
  parameter int OOB_VALUE    = 1
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  input  logic                      map_select_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ*DATA_W-1:0] data_out,
  output logic [NUM_REQ-1:0]        valid_out,
  output logic [ADDR_W-1:0]         map_addra_out,
  input  logic [DATA_W-1:0]         map_data1_in,
  input  logic [DATA_W-1:0]         map_data2_in,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic                      busy_out
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One stage for the registered address plus BRAM_LATENCY stages inside the BRAM.
  localparam int PIPE_D = BRAM_LATENCY + 1;
  localparam logic [ADDR_W:0] MAP_DEPTH = (ADDR_W+1)'(N*N);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] ret_onehot;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  int                 cand_sum;
  logic               grant_valid;
  logic [ADDR_W-1:0]  grant_addr;
  logic               grant_oob;
  logic [DATA_W-1:0]  ret_data;

  logic               tag_valid [PIPE_D];
  logic [IDX_W-1:0]   tag_idx   [PIPE_D];
  logic               tag_sel   [PIPE_D];
  logic               tag_oob   [PIPE_D];

  // A requester already waiting, or seeing its data this cycle, must not be
  // re-granted; its address may be stale until the FSM has reacted.
  assign elig = req_in & ~pending & ~valid_out;

  // A read counts as outstanding until the cycle its data is presented is over.
  assign busy_out = (|pending) | (|valid_out);

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_sum    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = int'(last_grant) + k;
      if (cand_sum >= NUM_REQ) begin
        cand_sum = cand_sum - NUM_REQ;
      end
      cand = cand_sum[IDX_W-1:0];
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Expand the winner into a one-hot grant and pick its address slice.
  always_comb begin
    grant_onehot = '0;
    grant_addr   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_valid && (grant_idx == IDX_W'(k))) begin
        grant_onehot[k] = 1'b1;
        grant_addr      = addr_in[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign grant_oob = ({1'b0, grant_addr} >= MAP_DEPTH);

  // Decode the tag leaving the pipeline into the requester it belongs to.
  always_comb begin
    ret_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (tag_valid[PIPE_D-1] && (tag_idx[PIPE_D-1] == IDX_W'(k))) begin
        ret_onehot[k] = 1'b1;
      end
    end
  end

  // Choose the returned cell: out-of-range reads see a wall, otherwise the map latched at grant.
  always_comb begin
    ret_data = map_data1_in;
    if (tag_oob[PIPE_D-1]) begin
      ret_data = DATA_W'(OOB_VALUE);
    end else if (tag_sel[PIPE_D-1]) begin
      ret_data = map_data2_in;
    end
  end

  // Issue side: register the granted address and grant, remember the winner.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      map_addra_out <= '0;
      grant_out     <= '0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant_out <= grant_onehot;
      if (grant_valid) begin
        map_addra_out <= grant_addr;
        last_grant    <= grant_idx;
      end
    end
  end

  // Tag pipeline: shifts every cycle so a tag exits exactly when its BRAM data is valid.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < PIPE_D; s++) begin
        tag_valid[s] <= 1'b0;
        tag_idx[s]   <= '0;
        tag_sel[s]   <= 1'b0;
        tag_oob[s]   <= 1'b0;
      end
    end else begin
      tag_valid[0] <= grant_valid;
      tag_idx[0]   <= grant_idx;
      tag_sel[0]   <= map_select_in;
      tag_oob[0]   <= grant_oob;
      for (int s = 1; s < PIPE_D; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
        tag_sel[s]   <= tag_sel[s-1];
        tag_oob[s]   <= tag_oob[s-1];
      end
    end
  end

  // Return side: deliver data to its owner, pulse valid and retire the pending bit.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      valid_out <= '0;
      data_out  <= '0;
      pending   <= '0;
    end else begin
      valid_out <= ret_onehot;
      pending   <= (pending | grant_onehot) & ~ret_onehot;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (ret_onehot[k]) begin
          data_out[k*DATA_W +: DATA_W] <= ret_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_req_arbiter.sv
// tb_map_req_arbiter: drives map_req_arbiter with directed scenarios and
// randomized FSM-like requesters, and compares every cycle against a
// transaction-level model (grant order, in-flight reads and their return times).
module tb_map_req_arbiter;

  localparam int NR    = 2;
  localparam int AW    = 10;
  localparam int DW    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 576;

  typedef struct {
    int             due;
    int             idx;
    logic [DW-1:0]  val;
  } flight_t;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  addr_bus = '0;
  logic [NR*DW-1:0]  data_out;
  logic [NR-1:0]     valid;
  logic [AW-1:0]     map_addra;
  logic [DW-1:0]     map_data1;
  logic [DW-1:0]     map_data2;
  logic [NR-1:0]     grant;
  logic              busy;

  logic [DW-1:0]     mem1 [1024];
  logic [DW-1:0]     mem2 [1024];
  logic [DW-1:0]     b1a, b1b, b2a, b2b;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  logic [NR-1:0]     m_pending = '0;
  logic [NR-1:0]     m_valid = '0;
  logic [NR-1:0]     m_grant = '0;
  logic [NR-1:0]     m_elig;
  logic [NR-1:0]     m_ret;
  logic [AW-1:0]     m_addr = '0;
  logic [AW-1:0]     m_a;
  logic [DW-1:0]     m_data [NR];
  logic [NR*DW-1:0]  exp_data;
  int                m_last = NR - 1;
  int                m_g;
  int                edge_n = 0;
  flight_t           flight [$];
  flight_t           f;

  map_req_arbiter #(
    .NUM_REQ(NR), .N(24), .ADDR_W(AW), .DATA_W(DW), .BRAM_LATENCY(LAT), .OOB_VALUE(1)
  ) dut (
    .pixel_clk_in (clock),
    .rst_n_in     (rst_n),
    .map_select_in(sel),
    .req_in       (req),
    .addr_in      (addr_bus),
    .data_out     (data_out),
    .valid_out    (valid),
    .map_addra_out(map_addra),
    .map_data1_in (map_data1),
    .map_data2_in (map_data2),
    .grant_out    (grant),
    .busy_out     (busy)
  );

  always #5 clock = ~clock;

  // Two-stage registered read models the BRAM pair with latency 2.
  always @(posedge clock) begin
    b1a <= mem1[map_addra];
    b1b <= b1a;
    b2a <= mem2[map_addra];
    b2b <= b2a;
  end
  assign map_data1 = b1b;
  assign map_data2 = b2b;

  // Transaction model: pick the round-robin winner, record what the read must
  // return and after how many edges, and retire reads whose time has come.
  always @(posedge clock) begin
    if (!rst_n) begin
      m_pending = '0;
      m_valid   = '0;
      m_grant   = '0;
      m_addr    = '0;
      m_last    = NR - 1;
      for (int i = 0; i < NR; i++) m_data[i] = '0;
      flight.delete();
    end else begin
      m_elig = req & ~m_pending & ~m_valid;
      m_ret  = '0;
      if (flight.size() > 0 && flight[0].due == edge_n) begin
        f = flight.pop_front();
        m_ret[f.idx] = 1'b1;
        m_data[f.idx] = f.val;
      end
      m_g = -1;
      for (int k = 1; k <= NR; k++) begin
        if (m_g < 0 && m_elig[(m_last + k) % NR]) m_g = (m_last + k) % NR;
      end
      m_grant = '0;
      if (m_g >= 0) begin
        m_grant[m_g] = 1'b1;
        m_last = m_g;
        m_a = addr_bus[m_g*AW +: AW];
        m_addr = m_a;
        f.due = edge_n + LAT + 1;
        f.idx = m_g;
        f.val = (int'(m_a) >= DEPTH) ? DW'(1) : (sel ? mem2[m_a] : mem1[m_a]);
        flight.push_back(f);
      end
      m_valid   = m_ret;
      m_pending = (m_pending | m_grant) & ~m_ret;
    end
    edge_n++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the active edge, hold the DUT to the model.
  always @(negedge clock) begin
    if (check_en) begin
      for (int i = 0; i < NR; i++) exp_data[i*DW +: DW] = m_data[i];
      checkOutput("cyc_grant", 32'(grant), 32'(m_grant));
      checkOutput("cyc_addr", 32'(map_addra), 32'(m_addr));
      checkOutput("cyc_valid", 32'(valid), 32'(m_valid));
      checkOutput("cyc_data", 32'(data_out), 32'(exp_data));
      checkOutput("cyc_busy", 32'(busy), 32'((|m_pending) | (|m_valid)));
    end
  end

  task automatic nextCycle();
    @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    rst_n = 1'b0;
    req = '0;
    sel = 1'b0;
    addr_bus = '0;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pickAddr();
    if ($urandom_range(0, 7) == 0) return AW'(DEPTH + $urandom_range(0, 447));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) begin
        if (m_valid[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else addr_bus[i*AW +: AW] = pickAddr();
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            addr_bus[i*AW +: AW] = pickAddr();
          end
        end else if (m_pending[i] && $urandom_range(0, 9) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem1[a] = DW'($urandom);
      mem2[a] = ~mem1[a];
    end
    mem1[DEPTH] = 4'h0;
    mem2[DEPTH] = 4'hF;

    @(negedge clock);
    @(negedge clock);
    check_en = 1'b1;

    // Single request
    doReset();
    req = 2'b01; addr_bus[0 +: AW] = 10'd25; sel = 1'b0;
    nextCycle();
    checkOutput("single_grant_c1", 32'(grant), 32'h1);
    checkOutput("single_addr_c1", 32'(map_addra), 32'd25);
    checkOutput("single_busy_c1", 32'(busy), 32'h1);
    nextCycle(); nextCycle();
    checkOutput("single_novalid_c3", 32'(valid), 32'h0);
    checkOutput("single_busy_c3", 32'(busy), 32'h1);
    nextCycle();
    checkOutput("single_valid_c4", 32'(valid), 32'h1);
    checkOutput("single_data_c4", 32'(data_out[3:0]), 32'(mem1[25]));
    checkOutput("single_busy_c4", 32'(busy), 32'h1);
    req = 2'b00;
    nextCycle();
    checkOutput("single_busy_c5", 32'(busy), 32'h0);
    checkOutput("single_valid_c5", 32'(valid), 32'h0);

    // Contention
    doReset();
    req = 2'b11; addr_bus = {10'd31, 10'd30};
    nextCycle();
    checkOutput("cont_grant_c1", 32'(grant), 32'h1);
    nextCycle();
    checkOutput("cont_grant_c2", 32'(grant), 32'h2);
    nextCycle(); nextCycle();
    checkOutput("cont_valid_c4", 32'(valid), 32'h1);
    checkOutput("cont_data0_c4", 32'(data_out[3:0]), 32'(mem1[30]));
    req = 2'b10;
    nextCycle();
    checkOutput("cont_valid_c5", 32'(valid), 32'h2);
    checkOutput("cont_data1_c5", 32'(data_out[7:4]), 32'(mem1[31]));
    req = 2'b00;
    nextCycle();
    req = 2'b01; addr_bus[0 +: AW] = 10'd40;
    nextCycle();
    checkOutput("cont_solo_grant_c7", 32'(grant), 32'h1);
    nextCycle(); nextCycle(); nextCycle();
    req = 2'b00;
    nextCycle();
    req = 2'b11; addr_bus = {10'd42, 10'd41};
    nextCycle();
    checkOutput("cont_rr_first_c12", 32'(grant), 32'h2);
    nextCycle();
    checkOutput("cont_rr_second_c13", 32'(grant), 32'h1);
    nextCycle(); nextCycle();
    req = 2'b01;
    nextCycle();
    req = 2'b00;

    // Select latched at grant
    doReset();
    req = 2'b01; addr_bus[0 +: AW] = 10'd100; sel = 1'b1;
    nextCycle();
    sel = 1'b0;
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("sel_valid_c4", 32'(valid), 32'h1);
    checkOutput("sel_data_c4", 32'(data_out[3:0]), 32'(mem2[100]));
    req = 2'b00;

    // Out of range address
    doReset();
    req = 2'b01; addr_bus[0 +: AW] = 10'd576;
    nextCycle();
    checkOutput("oob_addr_c1", 32'(map_addra), 32'd576);
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("oob_valid_c4", 32'(valid), 32'h1);
    checkOutput("oob_data_c4", 32'(data_out[3:0]), 32'h1);
    req = 2'b00;

    // No double issue while pending or valid
    doReset();
    req = 2'b01; addr_bus[0 +: AW] = 10'd7;
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      checkOutput($sformatf("hold_grant_c%0d", c), 32'(grant),
                  (c == 1 || c == 6 || c == 11) ? 32'h1 : 32'h0);
    end
    req = 2'b00;

    // Reset mid-flight
    doReset();
    req = 2'b01; addr_bus[0 +: AW] = 10'd50;
    nextCycle();
    checkOutput("rst_grant_c1", 32'(grant), 32'h1);
    nextCycle();
    rst_n = 1'b0; req = 2'b00;
    nextCycle();
    checkOutput("rst_valid_c3", 32'(valid), 32'h0);
    checkOutput("rst_grant_c3", 32'(grant), 32'h0);
    checkOutput("rst_addr_c3", 32'(map_addra), 32'h0);
    checkOutput("rst_data_c3", 32'(data_out), 32'h0);
    checkOutput("rst_busy_c3", 32'(busy), 32'h0);
    rst_n = 1'b1; req = 2'b11; addr_bus = {10'd52, 10'd51};
    nextCycle();
    checkOutput("rst_first_grant_c4", 32'(grant), 32'h1);
    checkOutput("rst_novalid_c4", 32'(valid), 32'h0);
    nextCycle();
    checkOutput("rst_grant_c5", 32'(grant), 32'h2);
    checkOutput("rst_novalid_c5", 32'(valid), 32'h0);
    nextCycle();
    checkOutput("rst_novalid_c6", 32'(valid), 32'h0);
    nextCycle();
    checkOutput("rst_valid_c7", 32'(valid), 32'h1);
    req = 2'b10;
    nextCycle();
    checkOutput("rst_valid_c8", 32'(valid), 32'h2);
    req = 2'b00;

    // Randomized requesters against the model
    doReset();
    applyStimulus(4000);
    rst_n = 1'b1;
    req = '0;
    repeat (8) nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
